// File: rtl/noc_local_port_fifo.sv
// Local injection port: FWFT flit FIFO with XY route decode held per packet.
// Route is taken from the header flit and reused for body/tail flits.
module noc_local_port_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int N_ADD      = 2,
    parameter int DEPTH      = 4,
    parameter int PKT_LEN    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_ADD-1:0]         X_cur,
    input  logic [N_ADD-1:0]         Y_cur,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_val,
    output logic                     in_ret,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_val,
    output logic [4:0]               out_req,
    input  logic                     grant,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pkt_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic {IDLE, BODY} state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    state_t                state_q, state_d;
    logic [4:0]            route_q, route_d;
    logic [4:0]            route_c;
    logic [CW-1:0]         flit_q, flit_d;
    logic                  pkt_done_q, pkt_done_d;
    logic                  push, pop;
    logic [N_ADD-1:0]      x_dst, y_dst;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ret   = rst & ~full;
    assign push     = in_val & in_ret;
    assign out_val  = ~empty;
    assign pop      = grant & out_val;
    assign out_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign pkt_done = pkt_done_q;

    assign x_dst = out_data[2*N_ADD-1:N_ADD];
    assign y_dst = out_data[N_ADD-1:0];

    // Bit order: [0]=Local [1]=East [2]=West [3]=North [4]=South
    always_comb begin
        route_c = 5'b00001;
        if (x_dst > X_cur)      route_c = 5'b00010;
        else if (x_dst < X_cur) route_c = 5'b00100;
        else if (y_dst > Y_cur) route_c = 5'b01000;
        else if (y_dst < Y_cur) route_c = 5'b10000;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_comb begin
        state_d    = state_q;
        route_d    = route_q;
        flit_d     = flit_q;
        pkt_done_d = 1'b0;
        out_req    = 5'b00000;
        case (state_q)
            IDLE: begin
                if (out_val) out_req = route_c;
                if (pop) begin
                    route_d = route_c;
                    flit_d  = CW'(PKT_LEN-1);
                    if (PKT_LEN == 1) pkt_done_d = 1'b1;
                    else              state_d    = BODY;
                end
            end
            BODY: begin
                if (out_val) out_req = route_q;
                if (pop) begin
                    flit_d = flit_q - CW'(1);
                    if (flit_q == CW'(1)) begin
                        pkt_done_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            route_q    <= '0;
            flit_q     <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            route_q    <= route_d;
            flit_q     <= flit_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_noc_local_port_fifo.sv
// Randomised + directed bench for noc_local_port_fifo.
// A queue-based reference model predicts every output on the falling edge.
module tb_noc_local_port_fifo;

    localparam int DW    = 8;
    localparam int NA    = 2;
    localparam int DEPTH = 4;
    localparam int PL    = 3;

    logic          clk;
    logic          rst;
    logic [NA-1:0] X_cur, Y_cur;
    logic [DW-1:0] in_data;
    logic          in_val;
    logic          in_ret;
    logic [DW-1:0] out_data;
    logic          out_val;
    logic [4:0]    out_req;
    logic          grant;
    logic          full, empty;
    logic [$clog2(DEPTH):0] count;
    logic          pkt_done;

    noc_local_port_fifo #(
        .DATA_WIDTH(DW), .N_ADD(NA), .DEPTH(DEPTH), .PKT_LEN(PL)
    ) dut (
        .clk(clk), .rst(rst), .X_cur(X_cur), .Y_cur(Y_cur),
        .in_data(in_data), .in_val(in_val), .in_ret(in_ret),
        .out_data(out_data), .out_val(out_val), .out_req(out_req),
        .grant(grant), .full(full), .empty(empty), .count(count),
        .pkt_done(pkt_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [DW-1:0] q[$];
    int            pos;
    logic [4:0]    pkt_route;
    bit            exp_done;
    int            checks;
    int            passed;

    function automatic logic [4:0] xy(logic [DW-1:0] d,
                                      logic [NA-1:0] xc,
                                      logic [NA-1:0] yc);
        int xd, yd;
        xd = int'(d[2*NA-1:NA]);
        yd = int'(d[NA-1:0]);
        if (xd > int'(xc)) return 5'b00010;
        if (xd < int'(xc)) return 5'b00100;
        if (yd > int'(yc)) return 5'b01000;
        if (yd < int'(yc)) return 5'b10000;
        return 5'b00001;
    endfunction

    task automatic chk(string n, longint act, longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t",
                      n, act, exp, $time);
    endtask

    // Reference model: a flit queue plus position-in-packet.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            pos      = 0;
            exp_done = 0;
        end else begin
            bit do_pop, do_push;
            do_pop   = grant && (q.size() > 0);
            do_push  = in_val && (q.size() < DEPTH);
            exp_done = 0;
            if (do_pop) begin
                if (pos == 0) pkt_route = xy(q[0], X_cur, Y_cur);
                if (pos == PL-1) begin
                    exp_done = 1;
                    pos      = 0;
                end else begin
                    pos++;
                end
                void'(q.pop_front());
            end
            if (do_push) q.push_back(in_data);
        end
    end

    // Monitor: compare everything the DUT presents against the model.
    always @(negedge clk) begin
        logic [4:0] er;
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("in_ret", in_ret, rst && (q.size() < DEPTH));
        chk("out_val", out_val, q.size() > 0);
        chk("pkt_done", pkt_done, exp_done);
        chk("onehot", $countones(out_req) <= 1, 1);
        er = 5'b00000;
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0]);
            er = (pos == 0) ? xy(q[0], X_cur, Y_cur) : pkt_route;
        end
        chk("out_req", out_req, er);
    end

    task automatic drive(bit v, logic [DW-1:0] d, bit g);
        in_val  = v;
        in_data = d;
        grant   = g;
        @(negedge clk);
        #2;
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1);
    endtask

    logic [DW-1:0] hdrs [5];

    initial begin
        checks  = 0;
        passed  = 0;
        rst     = 1'b0;
        in_val  = 1'b0;
        in_data = '0;
        grant   = 1'b0;
        X_cur   = '0;
        Y_cur   = '0;
        @(negedge clk);
        #2;
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) drive(1'b0, '0, 1'b0);

        // Route decode: East, West, North, South, Local
        X_cur = 2'd1;
        Y_cur = 2'd1;
        hdrs = '{8'h09, 8'h01, 8'h06, 8'h04, 8'h05};
        foreach (hdrs[i]) begin
            drive(1'b1, hdrs[i], 1'b1);
            drive(1'b1, 8'hAA, 1'b1);
            drive(1'b1, 8'h55, 1'b1);
        end
        drain(3);

        // Wormhole hold: body flits decode Local but stay East
        X_cur = 2'd0;
        Y_cur = 2'd0;
        drive(1'b1, 8'h0C, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b1, 8'hFF, 1'b1);
        drain(3);

        // Full / backpressure: A4, A5 dropped
        for (int i = 0; i < 6; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0);
        drain(6);
        drive(1'b1, 8'hA6, 1'b1);
        drive(1'b1, 8'hA7, 1'b1);
        drain(3);

        // Simultaneous push/pop at count 2, then pop-only at full
        drive(1'b1, 8'hB0, 1'b0);
        drive(1'b1, 8'hB1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hB2 + 8'(i), 1'b1);
        drive(1'b1, 8'hB5, 1'b0);
        drive(1'b1, 8'hB6, 1'b0);
        drive(1'b1, 8'hC9, 1'b1);
        drain(5);

        // Reset mid-packet, next flit is a fresh header
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        drive(1'b1, 8'h0C, 1'b1);
        drive(1'b1, 8'h11, 1'b1);
        drive(1'b0, '0, 1'b0);
        rst = 1'b0;
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 8'h04, 1'b1);
        drain(3);

        // Random traffic with occasional route-origin changes and resets
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                X_cur = NA'($urandom);
                Y_cur = NA'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                drive(1'b0, '0, 1'b0);
                rst = 1'b1;
            end
            drive($urandom_range(0, 3) != 0, DW'($urandom),
                  $urandom_range(0, 2) != 0);
        end
        drain(8);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
